// File: rtl/sram_like_responder.sv
// Responder end of the SRAM-like bus: in-order data_ok/rdata over a synchronous single-port SRAM.
// Optional random accept stalls are enabled by defining SRAM_RESP_RAND_STALL_EN.
module sram_like_responder #(
  parameter int          ADDR_W          = 16,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]   count;
  logic               stall;
  logic               accept;
  logic [LATENCY-1:0] vld_p;
  logic [LATENCY-1:0] wr_p;
  logic [31:0]        rd_now;
  logic [31:0]        rdata_q;
  logic               rd_ret;
  logic               unused_addr;

  function automatic logic [3:0] write_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd0:    write_be = 4'b0001 << a;
      2'd1:    write_be = a[1] ? 4'b1100 : 4'b0011;
      default: write_be = 4'b1111;
    endcase
  endfunction

`ifdef SRAM_RESP_RAND_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = lfsr[0] & lfsr[1];
`else
  assign stall = 1'b0;
`endif

  // Accept stage: count==MAX blocks even when a retire happens this cycle
  assign addr_ok   = req & ~rst & (count < CNT_MAX) & ~stall;
  assign accept    = addr_ok;
  assign mem_en    = accept;
  assign mem_wen   = (accept & wr) ? write_be(size, addr[1:0]) : 4'b0000;
  assign mem_addr  = addr[ADDR_W+1:2];
  assign mem_wdata = wdata;
  assign unused_addr = ^{addr[31:ADDR_W+2]};

  always_ff @(posedge clk) begin
    if (rst)                      count <= '0;
    else if (accept && !data_ok)  count <= count + CNT_W'(1);
    else if (!accept && data_ok)  count <= count - CNT_W'(1);
  end

  // Delay line stages p0..p(LATENCY-1): control carries reset, data does not
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int k = 1; k < LATENCY; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    wr_p[0] <= wr;
    for (int k = 1; k < LATENCY; k++) wr_p[k] <= wr_p[k-1];
  end

  // Read data joins the line one stage behind its request, when the SRAM presents it
  if (LATENCY > 1) begin : g_data
    logic [31:0] data_p [1:LATENCY-1];

    always_ff @(posedge clk) begin
      data_p[1] <= mem_rdata;
      for (int k = 2; k < LATENCY; k++) data_p[k] <= data_p[k-1];
    end

    assign rd_now = data_p[LATENCY-1];
  end else begin : g_nodata
    assign rd_now = mem_rdata;
  end

  // Retire stage
  assign data_ok = vld_p[LATENCY-1] & ~rst;
  assign rd_ret  = data_ok & ~wr_p[LATENCY-1];
  assign rdata   = rd_ret ? rd_now : rdata_q;

  always_ff @(posedge clk) begin
    if (rst)         rdata_q <= '0;
    else if (rd_ret) rdata_q <= rd_now;
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed + random bench for sram_like_responder (LATENCY=3, MAX_OUTSTANDING=2) with an in-order scoreboard.
module tb_sram_like_responder;

  localparam int AW   = 8;
  localparam int LAT  = 3;
  localparam int MAXO = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          wr = 1'b0;
  logic [1:0]    size = 2'd0;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic          addr_ok, data_ok, mem_en;
  logic [31:0]   rdata, mem_wdata, mem_rdata;
  logic [3:0]    mem_wen;
  logic [AW-1:0] mem_addr;

  typedef struct {
    int          due;
    logic        wr;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] sram    [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  logic [31:0] hold = '0;
  int          ncmp = 0;
  int          nerr = 0;
  int          cyc = 0;
  int          stalls = 0;

  sram_like_responder #(
    .ADDR_W(AW), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port SRAM, 1-cycle read
  always @(posedge clk) begin
    if (mem_en) begin
      if (|mem_wen) begin
        for (int b = 0; b < 4; b++)
          if (mem_wen[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] be_model(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'd0)      return 4'b0001 << a;
    else if (sz == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
    else                 return 4'b1111;
  endfunction

  // Scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    logic [3:0]  be;
    logic [31:0] w;
    bit          exp_ok, exp_dok, acc;
    exp_t        e;
    if (rst) begin
      chk("addr_ok_in_rst", {31'b0, addr_ok}, 32'd0);
      chk("mem_en_in_rst", {31'b0, mem_en}, 32'd0);
      q.delete();
      hold = '0;
    end else begin
      exp_ok = req && (q.size() < MAXO);
`ifdef SRAM_RESP_RAND_STALL_EN
      if (!exp_ok) chk("addr_ok", {31'b0, addr_ok}, 32'd0);
      else if (!addr_ok) stalls++;
`else
      chk("addr_ok", {31'b0, addr_ok}, {31'b0, exp_ok});
`endif
      acc = req && addr_ok;
      chk("mem_en", {31'b0, mem_en}, {31'b0, acc});
      exp_dok = (q.size() > 0) && (q[0].due == cyc);
      chk("data_ok", {31'b0, data_ok}, {31'b0, exp_dok});
      if (exp_dok) begin
        e = q.pop_front();
        if (!e.wr) begin
          chk("rdata", rdata, e.data);
          hold = e.data;
        end else begin
          chk("rdata_hold_on_write", rdata, hold);
        end
      end else begin
        chk("rdata_hold", rdata, hold);
      end
      if (acc) begin
        be = wr ? be_model(size, addr[1:0]) : 4'b0000;
        chk("mem_wen", {28'b0, mem_wen}, {28'b0, be});
        chk("mem_addr", {24'b0, mem_addr}, {24'b0, addr[AW+1:2]});
        if (wr) chk("mem_wdata", mem_wdata, wdata);
        w = ref_mem[addr[AW+1:2]];
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
        ref_mem[addr[AW+1:2]] = w;
        e.due  = cyc + LAT;
        e.wr   = wr;
        e.data = w;
        q.push_back(e);
      end else begin
        chk("mem_wen_idle", {28'b0, mem_wen}, 32'd0);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept, leaving req asserted
  task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, output logic [3:0] wen_seen);
    bit ok = 0;
    int n = 0;
    wen_seen = 'x;
    req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
    while (!ok && n < 40) begin
      @(negedge clk);
      ok = addr_ok;
      if (ok) wen_seen = mem_wen;
      n++;
      @(posedge clk); #1;
    end
    chk("accept_timeout", {31'b0, ok}, 32'd1);
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [3:0] wen;
    int n;
    for (int i = 0; i < (1<<AW); i++) begin sram[i] = '0; ref_mem[i] = '0; end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data_ok", {31'b0, data_ok}, 32'd0);
    chk("rst_mem_wen", {28'b0, mem_wen}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    @(posedge clk); #1;

    // Word write then back-to-back read of the same word
    issue(1'b1, 2'd2, 32'h100, 32'hDEADBEEF, wen);
    chk("wen_word", {28'b0, wen}, 32'hF);
    issue(1'b0, 2'd2, 32'h100, 32'h0, wen);
    chk("wen_read", {28'b0, wen}, 32'h0);
    idle(6);

    // Byte lane merge
    issue(1'b1, 2'd2, 32'h100, 32'h11223344, wen);
    issue(1'b1, 2'd0, 32'h103, 32'hAAAAAAAA, wen);
    chk("wen_byte3", {28'b0, wen}, 32'h8);
    issue(1'b0, 2'd2, 32'h100, 32'h0, wen);
    idle(6);
    chk("byte_merge_word", ref_mem[8'h40], 32'hAA223344);

    // Half-word lanes
    issue(1'b1, 2'd1, 32'h102, 32'h55667788, wen);
    chk("wen_half_hi", {28'b0, wen}, 32'hC);
    issue(1'b1, 2'd1, 32'h100, 32'h99AABBCC, wen);
    chk("wen_half_lo", {28'b0, wen}, 32'h3);
    issue(1'b1, 2'd3, 32'h104, 32'h0BADF00D, wen);
    chk("wen_size3", {28'b0, wen}, 32'hF);
    issue(1'b0, 2'd2, 32'h100, 32'h0, wen);
    idle(6);

    // Sustained requests against the outstanding limit
    for (int i = 0; i < 5; i++) issue(1'b0, 2'd2, 32'h100 + 32'(4*(i%2)), 32'h0, wen);
    idle(6);

    // Reset with two reads in flight
    issue(1'b0, 2'd2, 32'h100, 32'h0, wen);
    issue(1'b0, 2'd2, 32'h104, 32'h0, wen);
    rst = 1'b1;
    @(negedge clk);
    chk("addr_ok_during_rst", {31'b0, addr_ok}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_data_ok_after_rst", {31'b0, data_ok}, 32'd0);
    end
    @(posedge clk); #1;

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            32'($urandom_range(0, 63)), $urandom, wen);
      idle($urandom_range(0, 2));
    end

    idle(0);
    n = 0;
    while (q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("drain", q.size(), 32'd0);
`ifdef SRAM_RESP_RAND_STALL_EN
    chk("stall_seen", {31'b0, (stalls > 0)}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
